// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - E-stage HI/LO operation request and HI/LO/busy result bundle
interface muldiv_unit_if;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mdop, rs_val, rt_val,
    input  busy, hi, lo
  );

  modport slave (
    input  start, mdop, rs_val, rt_val,
    output busy, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MIPS multiply/divide unit owning HI/LO
// Optional madd/maddu/msub/msubu accumulate ops are enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic [63:0]   prod_s, prod_u;
  logic          div_zero, div_ovf;
  logic [31:0]   div_bs, div_bu;
  logic [31:0]   quo_s, rem_s, quo_u, rem_u;

  assign prod_s = $signed({{32{bus.rs_val[31]}}, bus.rs_val}) *
                  $signed({{32{bus.rt_val[31]}}, bus.rt_val});
  assign prod_u = {32'b0, bus.rs_val} * {32'b0, bus.rt_val};

  // Zero and INT_MIN/-1 divisors are replaced by 1: the latter then yields
  // exactly the required 0x80000000 quotient and 0 remainder.
  assign div_zero = (bus.rt_val == 32'd0);
  assign div_ovf  = (bus.rs_val == 32'h8000_0000) && (bus.rt_val == 32'hFFFF_FFFF);
  assign div_bs   = (div_zero || div_ovf) ? 32'd1 : bus.rt_val;
  assign div_bu   = div_zero ? 32'd1 : bus.rt_val;
  assign quo_s    = $signed(bus.rs_val) / $signed(div_bs);
  assign rem_s    = $signed(bus.rs_val) % $signed(div_bs);
  assign quo_u    = bus.rs_val / div_bu;
  assign rem_u    = bus.rs_val % div_bu;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.mdop)
            4'd1: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = BUSY;
            end
            4'd2: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = BUSY;
            end
            4'd3: begin
              pend_hi_d = rem_s;
              pend_lo_d = quo_s;
              pend_wr_d = !div_zero;
              cnt_d     = CW'(DIV_CYCLES);
              state_d   = BUSY;
            end
            4'd4: begin
              pend_hi_d = rem_u;
              pend_lo_d = quo_u;
              pend_wr_d = !div_zero;
              cnt_d     = CW'(DIV_CYCLES);
              state_d   = BUSY;
            end
            4'd5: hi_d = bus.rs_val;
            4'd6: lo_d = bus.rs_val;
`ifdef MULDIV_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: begin
              case (bus.mdop)
                4'd7:    {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
                4'd8:    {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
                4'd9:    {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_s;
                default: {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_u;
              endcase
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              state_d   = BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit (MULDIV_MADD_EN adds madd-family checks)
module tb_muldiv_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit_if bus();

  muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          t;
    int          due;
    int          n;
    logic [31:0] ph;
    logic [31:0] pl;
    logic [31:0] eh;
    logic [31:0] el;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          armed = 0;
  bit          warned = 0;
  logic [31:0] mh = 32'd0;
  logic [31:0] ml = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected busy window is (t, due); hi/lo must hold their pre-op values there.
  always @(negedge clk) begin
    bit eb;
    eb = 1'b0;
    if (armed) begin
      if (q.size() > 0 && q[0].n > 0 && cyc > q[0].t && cyc < q[0].due) eb = 1'b1;
      chk("busy", {31'b0, bus.busy}, {31'b0, eb});
      if (eb) begin
        chk("hi_hold", bus.hi, q[0].ph);
        chk("lo_hold", bus.lo, q[0].pl);
      end
      if (q.size() > 0 && cyc == q[0].due) begin
        chk("hi", bus.hi, q[0].eh);
        chk("lo", bus.lo, q[0].el);
        void'(q.pop_front());
      end
    end
  end

  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n, output logic [31:0] nh, output logic [31:0] nl);
    longint      sa, sb;
    logic [63:0] p, acc;
    n   = 0;
    nh  = mh;
    nl  = ml;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {mh, ml};
    case (op)
      4'd1: begin p = sa * sb; {nh, nl} = p; n = MC; end
      4'd2: begin p = {32'b0, a} * {32'b0, b}; {nh, nl} = p; n = MC; end
      4'd3: begin
        n = DC;
        if (b != 32'd0) begin
          p = sa / sb; nl = p[31:0];
          p = sa % sb; nh = p[31:0];
        end
      end
      4'd4: begin
        n = DC;
        if (b != 32'd0) begin nl = a / b; nh = a % b; end
      end
      4'd5: nh = a;
      4'd6: nl = a;
`ifdef MULDIV_MADD_EN
      4'd7:  begin p = sa * sb; {nh, nl} = acc + p; n = MC; end
      4'd8:  begin p = {32'b0, a} * {32'b0, b}; {nh, nl} = acc + p; n = MC; end
      4'd9:  begin p = sa * sb; {nh, nl} = acc - p; n = MC; end
      4'd10: begin p = {32'b0, a} * {32'b0, b}; {nh, nl} = acc - p; n = MC; end
`endif
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit wait_done, input bit garbage);
    int          n;
    logic [31:0] nh, nl;
    exp_t        e;
    model(op, a, b, n, nh, nl);
    e.t = cyc; e.due = cyc + n + 1; e.n = n;
    e.ph = mh; e.pl = ml; e.eh = nh; e.el = nl;
    q.push_back(e);
    mh = nh;
    ml = nl;
    bus.start = 1'b1; bus.mdop = op; bus.rs_val = a; bus.rt_val = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (wait_done) begin
      repeat (n) begin
        if (garbage) begin
          if (!warned) $display("warning: start asserted while busy (expected to be ignored)");
          warned = 1;
          bus.start  = 1'b1;
          bus.mdop   = 4'($urandom_range(1, 10));
          bus.rs_val = $urandom;
          bus.rt_val = $urandom;
        end
        @(posedge clk); #1;
      end
      bus.start = 1'b0;
    end
  endtask

  task automatic do_reset();
    exp_t e;
    if (q.size() > 0) begin
      e = q[0];
    end else begin
      e.t = cyc; e.n = 0; e.ph = 32'd0; e.pl = 32'd0;
    end
    q.delete();
    e.due = cyc + 1; e.eh = 32'd0; e.el = 32'd0;
    q.push_back(e);
    mh = 32'd0;
    ml = 32'd0;
    reset = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.mdop = 4'd0; bus.rs_val = 32'd0; bus.rt_val = 32'd0;
    @(posedge clk); #1;
    armed = 1;
    do_reset();

    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1, 0);
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1, 0);
    issue(4'd5, 32'h11, 32'd0, 1, 0);
    issue(4'd6, 32'h22, 32'd0, 1, 0);
    issue(4'd4, 32'd7, 32'd0, 1, 0);
    issue(4'd5, 32'hDEAD_BEEF, 32'd0, 1, 0);
    issue(4'd6, 32'h1234_5678, 32'd0, 1, 0);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    issue(4'd7, 32'd3, 32'd4, 1, 0);

    issue(4'd1, 32'd5, 32'd6, 0, 0);
    bus.start = 1'b1; bus.mdop = 4'd3; bus.rs_val = 32'd9; bus.rt_val = 32'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();

`ifdef MULDIV_MADD_EN
    issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1, 0);
    issue(4'd8, 32'd1, 32'd1, 1, 0);
    issue(4'd9, 32'hFFFF_FFFD, 32'd7, 1, 0);
    issue(4'd10, 32'hFFFF_FFFF, 32'd2, 1, 0);
`endif

    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick(), 1, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
